// File: rtl/pc_sequencer.sv
// Next-PC controller and program-counter register: sequential, jump and branch targets, busywait hold.
// Optional feature: define PC_BNE_EN to let BNE (taken when ZERO=0) redirect the PC.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          OFFSET_W     = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                IMEM_BUSYWAIT,
  input  logic                DMEM_BUSYWAIT,
  input  logic                JUMP,
  input  logic                BRANCH,
  input  logic                BNE,
  input  logic                ZERO,
  input  logic [OFFSET_W-1:0] OFFSET,
  output logic [31:0]         PC,
  output logic [31:0]         PC_PLUS4,
  output logic                FETCH_REQ,
  output logic                STALL,
  output logic                REDIRECT
);

  localparam logic [1:0] INIT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic        busy;
  logic        taken;
  logic        advance;
  logic [31:0] target;

  assign busy     = IMEM_BUSYWAIT | DMEM_BUSYWAIT;
  assign PC_PLUS4 = PC + 32'd4;
  assign STALL    = (state == INIT) | busy;
  // The PC only moves once out of INIT and with both memories ready.
  assign advance  = (state != INIT) & ~busy;

  // Word offset is sign-extended and scaled to bytes; wrap-around is intended.
  assign target = PC_PLUS4 + {{(32-OFFSET_W-2){OFFSET[OFFSET_W-1]}}, OFFSET, 2'b00};

`ifdef PC_BNE_EN
  assign taken = JUMP | (BRANCH & ZERO) | (BNE & ~ZERO);
`else
  assign taken = JUMP | (BRANCH & ZERO);
  logic unused_bne;
  assign unused_bne = BNE;
`endif

  // NOTE: combinational blocks assign a default first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      INIT:      state_next = RUN;
      RUN, HOLD: state_next = busy ? HOLD : RUN;
      default:   state_next = INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= INIT;
      PC        <= RESET_VECTOR;
      FETCH_REQ <= 1'b0;
      REDIRECT  <= 1'b0;
    end else begin
      state     <= state_next;
      FETCH_REQ <= 1'b1;
      REDIRECT  <= advance & taken;
      if (advance) begin
        PC <= taken ? target : PC_PLUS4;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: stimulus pushes expected cycle views into a queue,
// a negedge monitor pops and compares them against the DUT.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic        DMEM_BUSYWAIT = 1'b0;
  logic        JUMP = 1'b0;
  logic        BRANCH = 1'b0;
  logic        BNE = 1'b0;
  logic        ZERO = 1'b0;
  logic [7:0]  OFFSET = 8'h00;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic        FETCH_REQ;
  logic        STALL;
  logic        REDIRECT;

  pc_sequencer #(.RESET_VECTOR(RV), .OFFSET_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
    .JUMP(JUMP), .BRANCH(BRANCH), .BNE(BNE), .ZERO(ZERO), .OFFSET(OFFSET),
    .PC(PC), .PC_PLUS4(PC_PLUS4), .FETCH_REQ(FETCH_REQ), .STALL(STALL), .REDIRECT(REDIRECT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] plus4;
    logic        fetch;
    logic        stall;
    logic        redirect;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: what the program counter is, whether fetching has started, and whether
  // the last update was a taken redirect. The first edge at time 5 applies reset.
  logic [31:0] m_pc = RV;
  logic        m_active = 1'b0;
  logic        m_redirect = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic imem, input logic dmem, input logic jmp,
                       input logic br, input logic bne, input logic zero, input logic [7:0] off);
    exp_t e;
    logic take;
    @(posedge CLK);
    #1;
    RESET = rst; IMEM_BUSYWAIT = imem; DMEM_BUSYWAIT = dmem;
    JUMP = jmp; BRANCH = br; BNE = bne; ZERO = zero; OFFSET = off;
    e.pc       = m_pc;
    e.plus4    = m_pc + 32'd4;
    e.fetch    = m_active;
    e.stall    = !m_active || imem || dmem;
    e.redirect = m_redirect;
    exp_q.push_back(e);
    take = jmp || (br && zero);
`ifdef PC_BNE_EN
    take = take || (bne && !zero);
`endif
    if (!rst) begin
      m_pc = RV; m_active = 1'b0; m_redirect = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1; m_redirect = 1'b0;
    end else if (imem || dmem) begin
      m_redirect = 1'b0;
    end else if (take) begin
      m_pc = m_pc + 32'd4 + (32'($signed(off)) << 2);
      m_redirect = 1'b1;
    end else begin
      m_pc = m_pc + 32'd4;
      m_redirect = 1'b0;
    end
  endtask

  task automatic idle();
    cycle(1, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  // Issue a jump landing on addr; the model PC must be running and addr within offset reach.
  task automatic goto(input logic [31:0] addr);
    logic [31:0] d;
    d = (addr - m_pc - 32'd4) >> 2;
    cycle(1, 0, 0, 1, 0, 0, 0, d[7:0]);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", PC, e.pc);
        check("pc_plus4", PC_PLUS4, e.plus4);
        check("fetch_req", {31'd0, FETCH_REQ}, {31'd0, e.fetch});
        check("stall", {31'd0, STALL}, {31'd0, e.stall});
        check("redirect", {31'd0, REDIRECT}, {31'd0, e.redirect});
      end
    end
  end

  initial begin : stimulus
    int guard;
    // Reset for two edges, then sequential run 0, 4, 8, 12.
    cycle(0, 0, 0, 0, 0, 0, 0, 8'h00);
    repeat (5) idle();
    // Jump back: reach 0x10, then JUMP with -2 lands on 0x0C.
    goto(32'h10);
    cycle(1, 0, 0, 1, 0, 0, 0, 8'hFE);
    idle();
    // beq taken / not taken at 0x20, then bne at 0x20.
    goto(32'h20);
    cycle(1, 0, 0, 0, 1, 0, 1, 8'd3);
    goto(32'h20);
    cycle(1, 0, 0, 0, 1, 0, 0, 8'd3);
    goto(32'h20);
    cycle(1, 0, 0, 0, 0, 1, 0, 8'd3);
    idle();
    // JUMP and BRANCH together.
    cycle(1, 0, 0, 1, 1, 0, 1, 8'd5);
    // Instruction-memory stall with a pending jump at 0x40.
    goto(32'h40);
    repeat (3) cycle(1, 1, 0, 1, 0, 0, 0, 8'd2);
    cycle(1, 0, 0, 1, 0, 0, 0, 8'd2);
    // Data-memory and dual stall.
    cycle(1, 0, 1, 0, 1, 0, 1, 8'd1);
    cycle(1, 1, 1, 0, 0, 0, 0, 8'd0);
    idle();
    // Wrap past the top of the address space, then reset colliding with a taken jump.
    goto(32'hFFFF_FFFC);
    idle();
    idle();
    cycle(0, 0, 0, 1, 0, 0, 0, 8'd7);
    idle();
    idle();
    // Reset asserted mid-hold.
    cycle(1, 1, 0, 0, 0, 0, 0, 8'd0);
    cycle(0, 1, 0, 1, 0, 0, 0, 8'd1);
    idle();
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30),
            1'($urandom_range(0, 1)), 8'($urandom));
    end
    idle();
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge CLK);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
